// File: rtl/imem_uart_loader.sv
// UART program loader for the instruction BRAM. It receives a framed image
// (SYNC, length, words, XOR checksum), writes it word by word, and releases the core.
module imem_uart_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          ADDR_W       = 10,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_W);

  localparam logic [1:0] CODE_LEN   = 2'd1;
  localparam logic [1:0] CODE_FRAME = 2'd2;
  localparam logic [1:0] CODE_CSUM  = 2'd3;

  // ---------------------------------------------------------------- RX engine
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_END} rx_state_t;

  rx_state_t        rx_state, rx_next;
  logic [1:0]       rx_sync;
  logic             rx_s, rx_prev;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             stop_bit;
  logic             bit_done;
  logic             byte_valid, frame_err;

  assign rx_s     = rx_sync[1];
  assign bit_done = (rx_state == RX_START) ? (bit_cnt == HALF_BIT) : (bit_cnt == FULL_BIT);

  // NOTE: state elements use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_next;
  end

  // NOTE: the default assignment before the case keeps this purely combinational.
  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s)         rx_next = RX_START;
      RX_START: if (bit_done)                 rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_done && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (bit_done)                 rx_next = RX_END;
      RX_END:                                 rx_next = RX_IDLE;
      default:                                rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
      stop_bit <= 1'b0;
    end else begin
      if (rx_state == RX_IDLE || bit_done) bit_cnt <= '0;
      else                                 bit_cnt <= bit_cnt + 1'b1;
      if (rx_state == RX_START) bit_idx <= '0;
      if (rx_state == RX_DATA && bit_done) begin
        rx_byte <= {rx_s, rx_byte[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (rx_state == RX_STOP && bit_done) stop_bit <= rx_s;
    end
  end

  always_comb begin
    byte_valid = (rx_state == RX_END) &&  stop_bit;
    frame_err  = (rx_state == RX_END) && !stop_bit;
  end

  // ----------------------------------------------------------------- Load FSM
  typedef enum logic [2:0] {
    L_IDLE, L_LEN_HI, L_LEN_LO, L_DATA, L_CSUM, L_DONE, L_ERR
  } load_state_t;

  load_state_t ld_state, ld_next;
  logic [7:0]  len_hi_q;
  logic [15:0] len_q;
  logic [15:0] len_in;
  logic [7:0]  csum_q;
  logic [1:0]  byte_cnt;
  logic        word_rdy;
  logic        is_sync, len_bad, last_word, in_frame;

  assign is_sync   = byte_valid && (rx_byte == SYNC_BYTE);
  assign len_in    = {len_hi_q, rx_byte};
  assign len_bad   = (len_in == 16'd0) || ({1'b0, len_in} > MAX_WORDS);
  assign last_word = (16'(imem_addr) == len_q - 16'd1);
  assign in_frame  = (ld_state == L_LEN_HI) || (ld_state == L_LEN_LO) ||
                     (ld_state == L_DATA)   || (ld_state == L_CSUM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ld_state <= L_IDLE;
    else      ld_state <= ld_next;
  end

  always_comb begin
    ld_next = ld_state;
    unique case (ld_state)
      L_IDLE, L_DONE, L_ERR: if (is_sync) ld_next = L_LEN_HI;
      L_LEN_HI: if (frame_err) ld_next = L_ERR;
                else if (byte_valid) ld_next = L_LEN_LO;
      L_LEN_LO: if (frame_err) ld_next = L_ERR;
                else if (byte_valid) ld_next = len_bad ? L_ERR : L_DATA;
      L_DATA:   if (frame_err) ld_next = L_ERR;
                else if (word_rdy && last_word) ld_next = L_CSUM;
      L_CSUM:   if (frame_err) ld_next = L_ERR;
                else if (byte_valid) ld_next = (rx_byte == csum_q) ? L_DONE : L_ERR;
      default:  ld_next = L_IDLE;
    endcase
  end

  // The strobe is issued the cycle after the 4th byte, so the whole word is in imem_din.
  always_comb begin
    imem_we  = (ld_state == L_DATA) && word_rdy;
    done     = (ld_state == L_DONE);
    cpu_hold = (ld_state != L_DONE);
    err      = (ld_state == L_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_addr <= '0;
      imem_din  <= '0;
      err_code  <= '0;
      len_hi_q  <= '0;
      len_q     <= '0;
      csum_q    <= '0;
      byte_cnt  <= '0;
      word_rdy  <= 1'b0;
    end else begin
      word_rdy <= byte_valid && (ld_state == L_DATA) && (byte_cnt == 2'd3);
      if (byte_valid) begin
        unique case (ld_state)
          L_IDLE, L_DONE, L_ERR: if (is_sync) begin
            imem_addr <= '0;
            err_code  <= '0;
            csum_q    <= '0;
            byte_cnt  <= '0;
          end
          L_LEN_HI: begin
            len_hi_q <= rx_byte;
            csum_q   <= csum_q ^ rx_byte;
          end
          L_LEN_LO: begin
            len_q    <= len_in;
            csum_q   <= csum_q ^ rx_byte;
            byte_cnt <= '0;
            if (len_bad) err_code <= CODE_LEN;
          end
          L_DATA: begin
            imem_din <= {imem_din[23:0], rx_byte};
            csum_q   <= csum_q ^ rx_byte;
            byte_cnt <= byte_cnt + 1'b1;
          end
          L_CSUM: if (rx_byte != csum_q) err_code <= CODE_CSUM;
          default: ;
        endcase
      end
      if (frame_err && in_frame) err_code <= CODE_FRAME;
      // Address stays on the final word so it never exceeds N-1.
      if (imem_we && !last_word) imem_addr <= imem_addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: directed frames plus randomized frames
// scored against a frame-level reference model.
module tb_imem_uart_loader;

  localparam int         CPB    = 16;
  localparam int         ADDR_W = 10;
  localparam logic [7:0] SYNC   = 8'hA5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rx  = 1'b1;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_din;
  logic              cpu_hold, done, err;
  logic [1:0]        err_code;

  always #5 clk = ~clk;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_din(imem_din),
    .cpu_hold(cpu_hold), .done(done), .err(err), .err_code(err_code)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor, sampled on the falling edge.
  logic [ADDR_W+31:0] seen_q[$];
  logic               we_prev  = 1'b0;
  int                 we_long  = 0;
  int                 hold_bad = 0;

  always @(negedge clk) begin
    if (imem_we) begin
      seen_q.push_back({imem_addr, imem_din});
      if (we_prev) we_long++;
    end
    we_prev = imem_we;
    if (done == cpu_hold) hold_bad++;
  end

  // Reference model: parses the byte stream of one frame.
  logic [7:0]         frame_q[$];
  int                 bad_idx;
  logic [ADDR_W+31:0] exp_q[$];
  logic               exp_done = 1'b0;
  logic               exp_err  = 1'b0;
  logic [1:0]         exp_code = 2'd0;

  task automatic run_model();
    int          i, n;
    logic [7:0]  x;
    logic [31:0] word;
    exp_q.delete();
    i = 0;
    while (i < frame_q.size() && frame_q[i] != SYNC) i++;
    if (i >= frame_q.size()) return;
    exp_done = 1'b0; exp_err = 1'b0; exp_code = 2'd0;
    i++;
    if (bad_idx == i || bad_idx == i + 1) begin exp_err = 1'b1; exp_code = 2'd2; return; end
    n = {frame_q[i], frame_q[i+1]};
    x = frame_q[i] ^ frame_q[i+1];
    i += 2;
    if (n == 0 || n > 2 ** ADDR_W) begin exp_err = 1'b1; exp_code = 2'd1; return; end
    for (int w = 0; w < n; w++) begin
      if (bad_idx >= i && bad_idx <= i + 3) begin exp_err = 1'b1; exp_code = 2'd2; return; end
      word = {frame_q[i], frame_q[i+1], frame_q[i+2], frame_q[i+3]};
      x = x ^ frame_q[i] ^ frame_q[i+1] ^ frame_q[i+2] ^ frame_q[i+3];
      exp_q.push_back({ADDR_W'(w), word});
      i += 4;
    end
    if (bad_idx == i) begin exp_err = 1'b1; exp_code = 2'd2; return; end
    if (frame_q[i] == x) exp_done = 1'b1;
    else begin exp_err = 1'b1; exp_code = 2'd3; end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0; repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (CPB) @(posedge clk); end
    rx = stop; repeat (CPB) @(posedge clk);
    rx = 1'b1; repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic send_bytes();
    foreach (frame_q[k]) send_byte(frame_q[k], (k == bad_idx) ? 1'b0 : 1'b1);
    repeat (4 * CPB) @(posedge clk);
  endtask

  task automatic check_status(input string tag);
    check({tag, ".done"},     done,     exp_done);
    check({tag, ".err"},      err,      exp_err);
    check({tag, ".err_code"}, err_code, exp_code);
    check({tag, ".cpu_hold"}, cpu_hold, !exp_done);
  endtask

  task automatic run_frame(input string tag);
    seen_q.delete();
    we_long  = 0;
    hold_bad = 0;
    send_bytes();
    run_model();
    check({tag, ".nwrites"}, seen_q.size(), exp_q.size());
    foreach (exp_q[k])
      if (k < seen_q.size()) check({tag, ".write"}, seen_q[k], exp_q[k]);
    check({tag, ".we_width"}, we_long, 0);
    check({tag, ".hold_vs_done"}, hold_bad, 0);
    check_status(tag);
  endtask

  task automatic good_frame();
    frame_q = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                8'h01, 8'h23, 8'h45, 8'h67, 8'h20};
    bad_idx = -1;
  endtask

  task automatic glitch();
    @(posedge clk); rx = 1'b0;
    repeat (CPB * 3 / 10) @(posedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
  endtask

  initial begin
    int n, kind;
    logic [7:0] x;

    // Reset and long idle.
    repeat (10) @(posedge clk);
    #1;
    check("rst.cpu_hold", cpu_hold, 1'b1);
    check("rst.done", done, 1'b0);
    check("rst.err", err, 1'b0);
    check("rst.imem_we", imem_we, 1'b0);
    rst = 1'b1;
    seen_q.delete();
    repeat (10000) @(posedge clk);
    check("idle.nwrites", seen_q.size(), 0);
    check_status("idle");

    // Glitch in IDLE, then a good load that must still frame correctly.
    glitch();
    check_status("glitch_idle");
    good_frame();
    frame_q.push_front(8'h55);
    run_frame("good");

    glitch();
    check_status("glitch_done");

    // Bad checksum, then recovery.
    good_frame(); frame_q[11] = 8'h21;
    run_frame("bad_csum");
    good_frame();
    run_frame("recover");

    // Length boundaries.
    frame_q = '{8'hA5, 8'h00, 8'h00}; bad_idx = -1;
    run_frame("len_zero");
    frame_q = '{8'hA5, 8'h04, 8'h01}; bad_idx = -1;
    run_frame("len_over");
    seen_q.delete();
    frame_q = '{8'hA5, 8'h04, 8'h00}; bad_idx = -1;
    send_bytes();
    check("len_max.err", err, 1'b0);
    check("len_max.cpu_hold", cpu_hold, 1'b1);
    check("len_max.nwrites", seen_q.size(), 0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (3) @(posedge clk); #2 rst = 1'b1;

    // Framing error on the 3rd data byte.
    good_frame(); bad_idx = 5;
    run_frame("frame_err");

    // Reset in the middle of a load.
    good_frame();
    run_frame("pre_reset");
    seen_q.delete();
    frame_q = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD}; bad_idx = -1;
    send_bytes();
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("midrst.imem_we", imem_we, 1'b0);
    check("midrst.imem_addr", imem_addr, 0);
    check("midrst.imem_din", imem_din, 0);
    check("midrst.cpu_hold", cpu_hold, 1'b1);
    check("midrst.done", done, 1'b0);
    check("midrst.err", err, 1'b0);
    check("midrst.err_code", err_code, 2'd0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    check("midrst.nwrites", seen_q.size(), 0);
    good_frame();
    run_frame("after_rst");

    // Randomized frames.
    for (int r = 0; r < 6; r++) begin
      frame_q.delete();
      bad_idx = -1;
      for (int j = $urandom_range(0, 2); j > 0; j--) frame_q.push_back(8'($urandom_range(0, 8'hA4)));
      frame_q.push_back(SYNC);
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        n = $urandom_range(1025, 65535);
        frame_q.push_back(8'(n >> 8));
        frame_q.push_back(8'(n));
      end else begin
        n = $urandom_range(1, 3);
        frame_q.push_back(8'h00);
        frame_q.push_back(8'(n));
        x = 8'(n);
        for (int j = 0; j < 4 * n; j++) begin
          frame_q.push_back(8'($urandom));
          x ^= frame_q[frame_q.size() - 1];
        end
        frame_q.push_back((kind == 1) ? ~x : x);
        if (kind == 2) begin
          bad_idx = $urandom_range(frame_q.size() - 4 * n - 3, frame_q.size() - 1);
          while (frame_q.size() > bad_idx + 1) void'(frame_q.pop_back());
        end
      end
      run_frame($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Writer for the core's instruction memory: receives a program image over a UART line and writes it word by word into the instruction BRAM write port.
- Holds the core in reset until a complete, checksum-verified image has been written.
- Sits between the board RX pin and the instruction BRAM port A write side.
- The core reads this memory only through its fetch port; this block is the sole writer.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200).
- ADDR_W, 10, instruction memory word-address width; max image = 2**ADDR_W words.
- SYNC_BYTE, 8'hA5, byte that starts a load.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  UART serial in, 8N1, idle high, asynchronous to clk.
- imem_we  output  1  one-cycle write strobe to instruction memory.
- imem_addr  output  ADDR_W  word address for the write.
- imem_din  output  32  write data.
- cpu_hold  output  1  high keeps the core in reset.
- done  output  1  image loaded and verified.
- err  output  1  sticky load error.
- err_code  output  2  error cause: 1 = length, 2 = framing, 3 = checksum.

Behaviour:
Reset (rst low, async):
- imem_we = 0, imem_addr = 0, imem_din = 0, cpu_hold = 1, done = 0, err = 0, err_code = 0.
- FSM returns to IDLE and the RX engine returns to idle.

RX engine:
- rx passes through a 2-flop synchronizer.
- A falling edge starts a bit timer. Start bit is re-checked at CLKS_PER_BIT/2; if rx is high there, it was a glitch and is ignored.
- Data bits are sampled LSB first at each following CLKS_PER_BIT.
- Stop bit is sampled once; a 0 there is a framing error.
- byte_valid pulses one cycle after the stop-bit sample.

Frame: SYNC, LEN_HI, LEN_LO, 4*N data bytes (each word MSB byte first), CSUM.
- N = {LEN_HI, LEN_LO}.
- CSUM = XOR of LEN_HI, LEN_LO and all data bytes.

Load FSM:
- IDLE: non-SYNC bytes and framing errors are ignored. SYNC → LEN_HI; cpu_hold=1, done=0, err=0, err_code=0, imem_addr=0, running XOR=0.
- LEN_HI → LEN_LO on a byte.
- LEN_LO: if N==0 or N>2**ADDR_W → ERR, code 1. Otherwise → DATA.
- DATA: bytes shift into imem_din from the MSB end. On the 4th byte of a word, imem_we=1 for exactly one cycle with that word's imem_addr and imem_din. imem_addr increments on the cycle after the strobe. After word N-1 is written → CSUM.
- CSUM: match → DONE; mismatch → ERR, code 3.
- DONE: done=1; cpu_hold falls in the same cycle done rises. A SYNC byte re-enters LEN_HI (cpu_hold=1, done=0).
- ERR: err=1, cpu_hold=1, no further writes. A SYNC byte re-enters LEN_HI and clears err and err_code.
- A framing error in LEN_HI, LEN_LO, DATA or CSUM → ERR, code 2; the partial word is not written.
- In DONE or ERR, a framing error is ignored.

Other rules:
- imem_we is never asserted outside DATA.
- imem_addr never exceeds N-1 during a load.
- Reset mid-load aborts immediately; already-written words are not erased.

Test Plan:
- Reset: hold rst low then release with rx idle → cpu_hold=1, done=0, err=0, imem_we never asserted for 10k cycles.
- Good load: send 55 (junk), then A5 00 02 DE AD BE EF 01 23 45 67 20 → exactly two imem_we pulses: addr 0 / 32'hDEADBEEF, then addr 1 / 32'h01234567. After the CSUM byte: done=1, cpu_hold=0, err=0.
- Bad checksum: same frame with CSUM 21 → both words written, err=1, err_code=3, done=0, cpu_hold=1. A following correct frame → done=1, err=0.
- Length errors:
  - A5 00 00 → err_code=1, no writes.
  - A5 04 01 (ADDR_W=10) → err_code=1, no writes.
- Framing/glitch:
  - Stop bit forced 0 on the 3rd data byte → err_code=2, no imem_we.
  - A 0.3-bit low pulse on rx in IDLE → no byte accepted, state unchanged.
- Reset mid-load: assert rst after LEN_LO plus 2 data bytes → all outputs take reset values at once, no imem_we. A full good load afterwards succeeds with addr starting at 0.
